// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - per-output round-robin arbiter with packet-long grant hold
module rr_arbiter #(
    parameter int NPORTS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req_in,
    input  logic [NPORTS-1:0] tail_in,
    input  logic              full_in,
    output logic [NPORTS-1:0] sel_out,
    output logic [NPORTS-1:0] rd_en_out,
    output logic              wr_en_out,
    output logic              busy_out
);

    // Only two states: waiting to arbitrate, or locked onto one packet.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [NPORTS-1:0] sel_n;
    logic              busy_n;
    logic [2:0]        last_grant;
    logic [2:0]        last_grant_n;

    logic              found;
    logic [2:0]        pick_idx;
    logic [3:0]        cand;
    logic [2:0]        grant_idx;
    logic              xfer;
    logic              tail_hit;

    // Round-robin scan: first requester after last_grant, wrapping modulo 5.
    always_comb begin
        found    = 1'b0;
        pick_idx = 3'd0;
        cand     = 4'd0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = {1'b0, last_grant} + k[3:0];
            if (cand >= 4'(NPORTS)) begin
                cand = cand - 4'(NPORTS);
            end
            if (!found && req_in[cand[2:0]]) begin
                found    = 1'b1;
                pick_idx = cand[2:0];
            end
        end
    end

    // Recover the granted index from the one-hot select for the pointer update.
    always_comb begin
        grant_idx = 3'd0;
        unique case (sel_out)
            5'b00001: grant_idx = 3'd0;
            5'b00010: grant_idx = 3'd1;
            5'b00100: grant_idx = 3'd2;
            5'b01000: grant_idx = 3'd3;
            5'b10000: grant_idx = 3'd4;
            default:  grant_idx = 3'd0;
        endcase
    end

    // A flit moves only when the granted input has one and downstream has room;
    // reset forces the strobes low immediately rather than waiting for sel_out.
    always_comb begin
        xfer      = (state == BUSY) && !rst && |(sel_out & req_in) && !full_in;
        tail_hit  = |(sel_out & tail_in);
        rd_en_out = xfer ? sel_out : '0;
        wr_en_out = xfer;
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the tail pops.
    always_comb begin
        state_n      = state;
        sel_n        = sel_out;
        busy_n       = busy_out;
        last_grant_n = last_grant;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    sel_n   = NPORTS'(1) << pick_idx;
                    busy_n  = 1'b1;
                end else begin
                    sel_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            BUSY: begin
                if (xfer && tail_hit) begin
                    state_n      = IDLE;
                    sel_n        = '0;
                    busy_n       = 1'b0;
                    last_grant_n = grant_idx;
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State register; pointer resets to L so N wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_out    <= '0;
            busy_out   <= 1'b0;
            last_grant <= 3'd4;
        end else begin
            state      <= state_n;
            sel_out    <= sel_n;
            busy_out   <= busy_n;
            last_grant <= last_grant_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req_in = '0;
    logic [4:0] tail_in = '0;
    logic       full_in = 1'b0;
    logic [4:0] sel_out;
    logic [4:0] rd_en_out;
    logic       wr_en_out;
    logic       busy_out;

    int tests = 0;
    int fails = 0;

    rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .tail_in   (tail_in),
        .full_in   (full_in),
        .sel_out   (sel_out),
        .rd_en_out (rd_en_out),
        .wr_en_out (wr_en_out),
        .busy_out  (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic [4:0] tail;
        logic       full;
        logic [4:0] sel;
        logic [4:0] rd;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [4:0] esel, input logic [4:0] erd,
                       input logic ewr, input logic ebusy);
        tests++;
        if (sel_out !== esel || rd_en_out !== erd || wr_en_out !== ewr || busy_out !== ebusy) begin
            fails++;
            $display("FAIL %s: got sel=%b rd=%b wr=%b busy=%b, want sel=%b rd=%b wr=%b busy=%b",
                     name, sel_out, rd_en_out, wr_en_out, busy_out, esel, erd, ewr, ebusy);
        end
    endtask

    function automatic void add(input logic [4:0] req, input logic [4:0] tail, input logic full,
                                input logic [4:0] sel, input logic [4:0] rd, input logic busy);
        vec_t v;
        v.req = req; v.tail = tail; v.full = full; v.sel = sel; v.rd = rd; v.busy = busy;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_in = '0; tail_in = '0; full_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state: granted port (-1 = none) and round-robin pointer.
    int m_grant;
    int m_ptr;

    initial begin
        // ---- Test 1: reset with requests pending ----
        rst = 1'b1; req_in = 5'b10101; tail_in = '0;
        @(negedge clk); #1;
        chk("reset_hold", 5'b00000, 5'b00000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_idle", 5'b00000, 5'b00000, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("first_grant_n", 5'b00001, 5'b00001, 1'b1, 1'b1);

        // ---- Tests 2-5: table of per-cycle vectors from a fresh reset ----
        // Round robin, single-flit packets.
        for (int i = 0; i < 6; i++) begin
            add(5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 1'b0);
            add(5'b11111, 5'b11111, 1'b0, 5'b00001 << (i % 5), 5'b00001 << (i % 5), 1'b1);
        end
        // Packet lock: E holds for 4 flits while W and L wait, then W, then L.
        add(5'b10110, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);
        add(5'b10110, 5'b00000, 1'b0, 5'b00010, 5'b00010, 1'b1);
        add(5'b10110, 5'b00000, 1'b0, 5'b00010, 5'b00010, 1'b1);
        add(5'b10110, 5'b00000, 1'b0, 5'b00010, 5'b00010, 1'b1);
        add(5'b10110, 5'b00010, 1'b0, 5'b00010, 5'b00010, 1'b1);
        add(5'b10110, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);
        add(5'b10110, 5'b00100, 1'b0, 5'b00100, 5'b00100, 1'b1);
        add(5'b10000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);
        add(5'b10000, 5'b10000, 1'b0, 5'b10000, 5'b10000, 1'b1);
        add(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);
        // Backpressure: S 3-flit packet stalled by full_in for three cycles.
        add(5'b01000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);
        add(5'b01000, 5'b00000, 1'b0, 5'b01000, 5'b01000, 1'b1);
        add(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 1'b1);
        add(5'b01000, 5'b01000, 1'b1, 5'b01000, 5'b00000, 1'b1);
        add(5'b01000, 5'b01000, 1'b1, 5'b01000, 5'b00000, 1'b1);
        add(5'b01000, 5'b00000, 1'b0, 5'b01000, 5'b01000, 1'b1);
        add(5'b01000, 5'b01000, 1'b0, 5'b01000, 5'b01000, 1'b1);
        add(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);
        // Request gap: L drops its request mid-packet while N waits.
        add(5'b10000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);
        add(5'b10000, 5'b00000, 1'b0, 5'b10000, 5'b10000, 1'b1);
        add(5'b00001, 5'b00001, 1'b0, 5'b10000, 5'b00000, 1'b1);
        add(5'b00001, 5'b00001, 1'b0, 5'b10000, 5'b00000, 1'b1);
        add(5'b10001, 5'b10000, 1'b0, 5'b10000, 5'b10000, 1'b1);
        add(5'b00001, 5'b00001, 1'b0, 5'b00000, 5'b00000, 1'b0);
        add(5'b00001, 5'b00001, 1'b0, 5'b00001, 5'b00001, 1'b1);
        add(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);

        do_reset();
        foreach (vecs[i]) begin
            req_in = vecs[i].req; tail_in = vecs[i].tail; full_in = vecs[i].full;
            #1;
            chk($sformatf("vec%0d", i), vecs[i].sel, vecs[i].rd, vecs[i].rd != 5'b00000, vecs[i].busy);
            @(negedge clk);
        end

        // ---- Randomized run against the reference model ----
        do_reset();
        m_grant = -1;
        m_ptr   = 4;
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] esel;
            logic [4:0] erd;
            logic       x;
            req_in  = 5'($urandom);
            tail_in = 5'($urandom);
            full_in = ($urandom_range(0, 3) == 0);
            #1;
            if (m_grant < 0) begin
                esel = '0; erd = '0; x = 1'b0;
            end else begin
                esel = 5'b00001 << m_grant;
                x    = req_in[m_grant] && !full_in;
                erd  = x ? esel : 5'b00000;
            end
            chk($sformatf("rand%0d", n), esel, erd, x, m_grant >= 0);
            @(posedge clk);
            if (m_grant < 0) begin
                for (int k = 1; k <= 5; k++) begin
                    if (m_grant < 0 && req_in[(m_ptr + k) % 5]) m_grant = (m_ptr + k) % 5;
                end
            end else if (x && tail_in[m_grant]) begin
                m_ptr   = m_grant;
                m_grant = -1;
            end
            @(negedge clk);
        end

        // ---- Test 6: asynchronous reset mid-packet ----
        do_reset();
        req_in = 5'b00100; tail_in = 5'b00000; full_in = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("w_busy_before_rst", 5'b00100, 5'b00100, 1'b1, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_clear", 5'b00000, 5'b00000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; req_in = 5'b00010;
        #1;
        chk("after_rst_idle", 5'b00000, 5'b00000, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("after_rst_grant_e", 5'b00010, 5'b00010, 1'b1, 1'b1);
        // Pointer back at L: with N and E both asking, N must win.
        do_reset();
        req_in = 5'b00011;
        @(negedge clk); #1;
        chk("ptr_reset_n_first", 5'b00001, 5'b00001, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
